uart_tx: RTL and testbench
==========================

# uart_tx

UART transmitter, the send-side counterpart of the UART RX path. Accepts a parallel word on a one-cycle valid strobe and serializes it LSB-first as start bit, data bits, optional parity bit and stop bit on `TX_OUT`, one bit per `CLK` cycle. `CLK` is the TX baud clock produced by the clock divider, and `Busy` tells the system controller when a new word can be issued.

## Interface
- `Data_width`, 8, number of data bits per frame (legal range 5..8).
- `CLK` input 1: TX baud clock; every frame bit lasts exactly one cycle.
- `RST` input 1: reset, asynchronous and active-low.
- `P_DATA` input `Data_width`: parallel word to send; sampled only on acceptance.
- `Data_Valid` input 1: one-cycle request to send `P_DATA`.
- `PAR_EN` input 1: 1 adds a parity bit to the frame; sampled on acceptance.
- `PAR_TYP` input 1: 0 means even parity, 1 means odd parity; sampled on acceptance.
- `TX_OUT` output 1: serial line, registered; idles high.
- `Busy` output 1: registered; high while a frame is on the line.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: `TX_OUT`=1, `Busy`=0. On a rising edge with `Data_Valid`=1:
  - latch `P_DATA`, `PAR_EN` and `PAR_TYP` into internal registers;
  - move to START.
- START: `TX_OUT`=0. Go to DATA and clear the bit counter.
- DATA: `TX_OUT`=latched bit[cnt], LSB first. The counter increments each cycle.
  - At cnt=`Data_width`-1, go to PARITY if the latched `PAR_EN`=1, otherwise go to STOP.
- PARITY: `TX_OUT` = XOR-reduce(latched data) XOR latched `PAR_TYP`. This makes even parity give an even count of ones over data+parity, and odd parity give an odd count. Then go to STOP.
- STOP: `TX_OUT`=1, then return to IDLE.
- `Data_Valid` while `Busy`=1 is ignored. No data is latched and the frame in flight is unaffected.
- Input changes after acceptance (`P_DATA`, `PAR_EN`, `PAR_TYP`) never affect the frame in flight.
- Parity is computed from the latched word, not the live `P_DATA`.
- Reset (any time, including mid-frame):
  - immediately `TX_OUT`=1, `Busy`=0, state IDLE;
  - counter and data register cleared to 0;
  - a partial frame is aborted and not resumed.

## Timing
- Acceptance edge E0 sees `Data_Valid`=1 in IDLE.
- Frame bits, counted from E0:
  - cycle 1 after E0: start bit (`TX_OUT`=0), `Busy`=1;
  - cycles 2..`Data_width`+1: data bits;
  - cycle `Data_width`+2: parity bit, if enabled;
  - next cycle: stop bit.
- Frame length: `Data_width`+2 cycles (11 with parity at the default width). `Busy` is high for exactly that many cycles.
- `TX_OUT` and `Busy` are both registered outputs and change together on the same edges; both are glitch-free.
- After the stop cycle the block spends at least one IDLE cycle with `TX_OUT`=1. A new `Data_Valid` is accepted on the first edge in IDLE.
- `Data_Valid` held high continuously therefore gives back-to-back frames with exactly one idle cycle between them.

## Configuration
- `UART_TX_PARITY_EN` defined: PARITY state, parity logic and the `PAR_EN`/`PAR_TYP` latches are compiled in, and behaviour is as described above.
- `UART_TX_PARITY_EN` undefined:
  - PARITY state and parity logic are removed;
  - the `PAR_EN`/`PAR_TYP` ports remain but are ignored;
  - every frame is start + data + stop (`Data_width`+2 cycles).

## Structure
- Shared package `uart_pkg` holds:
  - FSM state encoding constants (IDLE, START, DATA, PARITY, STOP);
  - parity-type constants (`PAR_EVEN`=0, `PAR_ODD`=1).
  - The RX side reuses the parity constants.
- Sub-module `uart_tx_serializer`:
  - holds the data register, bit counter and `ser_done` flag;
  - is loaded on acceptance and stepped by `ser_en` from the FSM.
- Parity generation and the output mux stay in `uart_tx`.

## Test plan
- Reset, then idle for 5 cycles: `TX_OUT`=1 and `Busy`=0 throughout.
- `P_DATA`=0xA5, `PAR_EN`=0:
  - `TX_OUT` over cycles 1..10 = 0,1,0,1,0,0,1,0,1,1;
  - `Busy` high for exactly 10 cycles.
- `P_DATA`=0xA5, `PAR_EN`=1:
  - `PAR_TYP`=0 gives parity bit 0;
  - `PAR_TYP`=1 gives parity bit 1;
  - 11-cycle frame ending with stop bit 1.
- `P_DATA`=0x01, `PAR_EN`=1, `PAR_TYP`=0 gives parity 1. Then change `P_DATA` to 0xFF in cycle 3: transmitted bits unchanged.
- Assert `Data_Valid` with 0x3C during data cycle 4 of a frame carrying 0x5A: ignored; only 0x5A is sent.
- Hold `Data_Valid`=1 with 0x55: consecutive frames separated by exactly one idle cycle.
- Pull `RST` low in data cycle 5: `TX_OUT`=1 and `Busy`=0 immediately. After release, the next `Data_Valid` sends a complete fresh frame.
- Build without `UART_TX_PARITY_EN` and send `PAR_EN`=1 with 0xA5: 10-cycle frame, no parity bit.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART TX and RX paths.
//   tx_state_e  : transmitter FSM state encoding (IDLE, START, DATA, PARITY, STOP)
//   PAR_EVEN    : PAR_TYP value selecting even parity (0)
//   PAR_ODD     : PAR_TYP value selecting odd parity (1)
//   MAX_DATA_W  : widest supported data word
//   parity_bit(): parity bit for a word (zero-extended to MAX_DATA_W) and type
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int MAX_DATA_W = 8;

  // Even parity: the bit that makes the total count of ones even.
  // Odd parity: its complement. Zero-extension does not change the result,
  // so narrower words can be passed in directly.
  function automatic logic parity_bit(input logic [MAX_DATA_W-1:0] data,
                                      input logic                  par_typ);
    logic even_bit;
    even_bit = ^data;
    return (par_typ == PAR_ODD) ? ~even_bit : even_bit;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// -----------------------------------------------------------------------------
// uart_tx_if
// Handshake and line signals between the system controller and uart_tx.
//   P_DATA     : parallel word to send
//   Data_Valid : one-cycle send request
//   PAR_EN     : add a parity bit to the frame
//   PAR_TYP    : 0 even parity, 1 odd parity
//   TX_OUT     : serial line (idles high)
//   Busy       : frame in progress
// Modports: master = system controller side, slave = uart_tx.
// -----------------------------------------------------------------------------
interface uart_tx_if #(
  parameter int Data_width = 8
);

  logic [Data_width-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  TX_OUT;
  logic                  Busy;

  modport master (
    output P_DATA, Data_Valid, PAR_EN, PAR_TYP,
    input  TX_OUT, Busy
  );

  modport slave (
    input  P_DATA, Data_Valid, PAR_EN, PAR_TYP,
    output TX_OUT, Busy
  );

endinterface

// File: rtl/uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// uart_tx_serializer
// Data register and bit counter for the UART transmitter.
//   clk, rst_n : baud clock, asynchronous active-low reset
//   load       : capture load_data into the data register
//   load_data  : word to capture
//   ser_clr    : clear the bit counter (takes priority over ser_en)
//   ser_en     : advance the bit counter by one
//   ser_done   : counter points at the last data bit
//   next_bit   : data bit selected by the counter value after this edge
//   data_o     : current contents of the data register
// -----------------------------------------------------------------------------
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int Data_width = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [Data_width-1:0] load_data,
  input  logic                  ser_clr,
  input  logic                  ser_en,
  output logic                  ser_done,
  output logic                  next_bit,
  output logic [Data_width-1:0] data_o
);

  localparam int CNT_W = $clog2(Data_width);

  logic [Data_width-1:0] data_q, data_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    if (load) begin
      data_d = load_data;
    end
    if (ser_clr) begin
      cnt_d = '0;
    end else if (ser_en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign ser_done = (cnt_q == CNT_W'(Data_width - 1));
  // Looks one edge ahead so the top can register TX_OUT without a cycle lag.
  assign next_bit = data_d[cnt_d];
  assign data_o   = data_q;

endmodule

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// UART transmitter: serialises a word LSB-first as start, data, optional
// parity and stop bits, one bit per CLK cycle (CLK is the TX baud clock).
//   Data_width : data bits per frame (5..8)
//   CLK        : TX baud clock
//   RST        : asynchronous active-low reset
//   bus        : uart_tx_if.slave (P_DATA, Data_Valid, PAR_EN, PAR_TYP in;
//                TX_OUT, Busy out, both registered)
// Build option: define UART_TX_PARITY_EN to compile in the PARITY state,
// parity generation and the PAR_EN/PAR_TYP latches. Without it PAR_EN and
// PAR_TYP are ignored and every frame is start + data + stop.
// -----------------------------------------------------------------------------
module uart_tx
  import uart_pkg::*;
#(
  parameter int Data_width = 8
) (
  input  logic      CLK,
  input  logic      RST,
  uart_tx_if.slave  bus
);

  tx_state_e             state_q, state_d;
  logic                  tx_out_q, tx_out_d;
  logic                  busy_q, busy_d;

  logic                  load;
  logic                  ser_clr;
  logic                  ser_en;
  logic                  ser_done;
  logic                  next_bit;
  logic [Data_width-1:0] data_word;

  uart_tx_serializer #(
    .Data_width (Data_width)
  ) u_ser (
    .clk       (CLK),
    .rst_n     (RST),
    .load      (load),
    .load_data (bus.P_DATA),
    .ser_clr   (ser_clr),
    .ser_en    (ser_en),
    .ser_done  (ser_done),
    .next_bit  (next_bit),
    .data_o    (data_word)
  );

`ifdef UART_TX_PARITY_EN
  logic par_en_q, par_en_d;
  logic par_typ_q, par_typ_d;
  logic par_bit;

  always_comb begin
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    if (load) begin
      par_en_d  = bus.PAR_EN;
      par_typ_d = bus.PAR_TYP;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      par_en_q  <= 1'b0;
      par_typ_q <= PAR_EVEN;
    end else begin
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
    end
  end

  // Taken from the latched word: it is stable while PARITY is being entered.
  assign par_bit = parity_bit(MAX_DATA_W'(data_word), par_typ_q);
`else
  // Ports stay for interface compatibility; nothing in this build reads them.
  logic unused_par;
  logic unused_data;
  assign unused_par  = ^{bus.PAR_EN, bus.PAR_TYP};
  assign unused_data = ^data_word;
`endif

  // State register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and serializer control
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    ser_clr = 1'b0;
    ser_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.Data_Valid) begin
          state_d = ST_START;
          load    = 1'b1;
        end
      end
      ST_START: begin
        state_d = ST_DATA;
        ser_clr = 1'b1;
      end
      ST_DATA: begin
        if (ser_done) begin
`ifdef UART_TX_PARITY_EN
          state_d = par_en_q ? ST_PARITY : ST_STOP;
`else
          state_d = ST_STOP;
`endif
        end else begin
          ser_en = 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the state being entered and then registered,
  // so TX_OUT and Busy switch together on the same edge with no glitches.
  always_comb begin
    tx_out_d = 1'b1;
    busy_d   = 1'b1;
    case (state_d)
      ST_IDLE:   busy_d   = 1'b0;
      ST_START:  tx_out_d = 1'b0;
      ST_DATA:   tx_out_d = next_bit;
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_out_d = par_bit;
`endif
      ST_STOP:   tx_out_d = 1'b1;
      default:   busy_d   = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      tx_out_q <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      tx_out_q <= tx_out_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.TX_OUT = tx_out_q;
  assign bus.Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
// Self-checking bench for uart_tx. Expected line levels come from a frame
// model built from the frame format (start, data LSB-first, optional parity,
// stop) and compared cycle by cycle on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_uart_tx;

  localparam int DW = 8;
`ifdef UART_TX_PARITY_EN
  localparam bit PARITY_BUILT = 1'b1;
`else
  localparam bit PARITY_BUILT = 1'b0;
`endif

  logic clk;
  logic rst_n;

  uart_tx_if #(.Data_width(DW)) bus ();

  uart_tx #(.Data_width(DW)) dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit exp_q[$];

  task automatic check(input string tag, input logic got, input logic exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b", tag, got, exp);
    end
  endtask

  // Reference frame: start 0, data LSB first, parity (if built and enabled)
  // chosen so data+parity has an even (PAR_TYP=0) or odd (PAR_TYP=1) count
  // of ones, then stop 1.
  function automatic void build_frame(input logic [DW-1:0] d, input logic pen,
                                      input logic ptyp);
    int ones;
    exp_q = {};
    exp_q.push_back(1'b0);
    ones = 0;
    for (int i = 0; i < DW; i++) begin
      exp_q.push_back(d[i]);
      if (d[i]) ones++;
    end
    if (PARITY_BUILT && pen) begin
      if (ptyp == 1'b0) exp_q.push_back((ones % 2) == 1);
      else              exp_q.push_back((ones % 2) == 0);
    end
    exp_q.push_back(1'b1);
  endfunction

  // Called just after a falling edge with the DUT idle. intr (1..n) injects
  // a one-cycle Data_Valid with intr_data during that frame cycle; late_data
  // replaces P_DATA (and PAR_EN/PAR_TYP are flipped) right after acceptance.
  task automatic run_frame(input string tag, input logic [DW-1:0] d,
                           input logic pen, input logic ptyp,
                           input int intr, input logic [DW-1:0] intr_data,
                           input logic [DW-1:0] late_data);
    int n;
    build_frame(d, pen, ptyp);
    n = exp_q.size();
    bus.P_DATA     = d;
    bus.PAR_EN     = pen;
    bus.PAR_TYP    = ptyp;
    bus.Data_Valid = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      bus.P_DATA     = late_data;
      bus.PAR_EN     = ~pen;
      bus.PAR_TYP    = ~ptyp;
      bus.Data_Valid = 1'b0;
      if (k == intr) begin
        bus.P_DATA     = intr_data;
        bus.Data_Valid = 1'b1;
      end
      check($sformatf("%s tx c%0d", tag, k), bus.TX_OUT, exp_q[k-1]);
      check($sformatf("%s busy c%0d", tag, k), bus.Busy, 1'b1);
    end
    @(negedge clk);
    bus.Data_Valid = 1'b0;
    check($sformatf("%s idle tx", tag), bus.TX_OUT, 1'b1);
    check($sformatf("%s idle busy", tag), bus.Busy, 1'b0);
    $display("frame %s data=%02h pen=%0d ptyp=%0d len=%0d", tag, d, pen, ptyp, n);
  endtask

  // Data_Valid held high: frames repeat with one idle cycle between them.
  task automatic run_b2b(input logic [DW-1:0] d, input int frames);
    int n;
    build_frame(d, 1'b0, 1'b0);
    n = exp_q.size();
    bus.P_DATA     = d;
    bus.PAR_EN     = 1'b0;
    bus.PAR_TYP    = 1'b0;
    bus.Data_Valid = 1'b1;
    @(posedge clk);
    for (int f = 0; f < frames; f++) begin
      for (int k = 1; k <= n; k++) begin
        @(negedge clk);
        check($sformatf("b2b f%0d tx c%0d", f, k), bus.TX_OUT, exp_q[k-1]);
        check($sformatf("b2b f%0d busy c%0d", f, k), bus.Busy, 1'b1);
      end
      @(negedge clk);
      if (f == frames - 1) bus.Data_Valid = 1'b0;
      check($sformatf("b2b f%0d gap tx", f), bus.TX_OUT, 1'b1);
      check($sformatf("b2b f%0d gap busy", f), bus.Busy, 1'b0);
      $display("frame b2b%0d data=%02h len=%0d", f, d, n);
    end
    @(negedge clk);
    check("b2b end busy", bus.Busy, 1'b0);
  endtask

  // Reset pulled low in frame cycle abort_cycle; outputs must go idle at once.
  task automatic run_abort(input logic [DW-1:0] d, input int abort_cycle);
    bus.P_DATA     = d;
    bus.PAR_EN     = 1'b1;
    bus.PAR_TYP    = 1'b0;
    bus.Data_Valid = 1'b1;
    @(posedge clk);
    for (int k = 1; k < abort_cycle; k++) begin
      @(negedge clk);
      bus.Data_Valid = 1'b0;
    end
    check("abort pre busy", bus.Busy, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort tx", bus.TX_OUT, 1'b1);
    check("abort busy", bus.Busy, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("abort hold tx", bus.TX_OUT, 1'b1);
      check("abort hold busy", bus.Busy, 1'b0);
    end
    $display("frame abort data=%02h at cycle %0d", d, abort_cycle);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] rd;
    logic          rpen, rptyp;
    int            rintr;

    rst_n          = 1'b0;
    bus.P_DATA     = '0;
    bus.Data_Valid = 1'b0;
    bus.PAR_EN     = 1'b0;
    bus.PAR_TYP    = 1'b0;
    repeat (2) @(negedge clk);
    check("reset tx", bus.TX_OUT, 1'b1);
    check("reset busy", bus.Busy, 1'b0);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("idle%0d tx", k), bus.TX_OUT, 1'b1);
      check($sformatf("idle%0d busy", k), bus.Busy, 1'b0);
    end

    run_frame("a5_nopar", 8'hA5, 1'b0, 1'b0, 0, 8'h00, 8'h00);
    run_frame("a5_even", 8'hA5, 1'b1, 1'b0, 0, 8'h00, 8'h00);
    run_frame("a5_odd", 8'hA5, 1'b1, 1'b1, 0, 8'h00, 8'h00);
    run_frame("01_late_ff", 8'h01, 1'b1, 1'b0, 0, 8'h00, 8'hFF);
    run_frame("5a_intr_3c", 8'h5A, 1'b0, 1'b0, 5, 8'h3C, 8'h5A);
    run_frame("5a_intr_stop", 8'h5A, 1'b1, 1'b1, 11, 8'h3C, 8'h00);
    run_b2b(8'h55, 3);
    run_abort(8'hC3, 6);
    run_frame("after_abort", 8'h96, 1'b1, 1'b1, 0, 8'h00, 8'h00);

    for (int t = 0; t < 30; t++) begin
      rd    = DW'($urandom);
      rpen  = 1'($urandom);
      rptyp = 1'($urandom);
      rintr = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 10)) : 0;
      run_frame($sformatf("rnd%0d", t), rd, rpen, rptyp, rintr,
                DW'($urandom), DW'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
